// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and handshake controller in front of a two-cycle signed multiplier.
// Latency: MULT/MULTU accepted in T updates HI/LO at the end of T+2; MTHI/MTLO write at the accepting edge.
// Backpressure: stall holds the EX stage while a product is in flight and the instruction touches HI/LO.
module mult_hilo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hilo_rdata,
  output logic        stall,
  output logic        mul_in_valid,
  output logic [31:0] mul_mcand,
  output logic [31:0] mul_mplier,
  input  logic [63:0] mul_product,
  input  logic        mul_out_valid
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        uns_q, uns_d;

  logic        op_is_mul;
  logic        op_uses_hilo;
  logic        accept;
  logic [31:0] hi_corr;

  // Instruction class decode: ops 0 and 7 are NOPs and never interact with HI/LO.
  always_comb begin
    op_is_mul    = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
    op_uses_hilo = (ex_op != 3'd0) && (ex_op != 3'd7);
  end

  // Handshake outputs; reset qualifies acceptance so nothing leaks out while rst_n is low.
  always_comb begin
    stall        = (state_q == ST_BUSY) && ex_valid && op_uses_hilo;
    accept       = rst_n && ex_valid && !stall;
    mul_in_valid = rst_n && (state_q == ST_IDLE) && ex_valid && op_is_mul;
    mul_mcand    = rs_data;
    mul_mplier   = rt_data;
  end

  // MFHI/MFLO read port; zero for anything not accepted, including stalled reads.
  always_comb begin
    hilo_rdata = 32'd0;
    if (accept && (ex_op == OP_MFHI)) begin
      hilo_rdata = hi_q;
    end else if (accept && (ex_op == OP_MFLO)) begin
      hilo_rdata = lo_q;
    end
  end

  // The multiplier is always signed; an unsigned upper word is recovered by adding
  // back each operand wherever the other operand's sign bit was misread as negative.
  always_comb begin
    hi_corr = mul_product[63:32];
    if (uns_q) begin
      hi_corr = mul_product[63:32]
              + (opa_q[31] ? opb_q : 32'd0)
              + (opb_q[31] ? opa_q : 32'd0);
    end
  end

  // Next-state: launch in IDLE, retire on product valid in BUSY, MT* writes when accepted.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    uns_d   = uns_q;

    if (state_q == ST_IDLE) begin
      // A stray product valid while idle belongs to nothing and is dropped.
      if (mul_in_valid) begin
        opa_d   = rs_data;
        opb_d   = rt_data;
        uns_d   = (ex_op == OP_MULTU);
        state_d = ST_BUSY;
      end
    end else begin
      // No timeout: only the product valid brings the controller back.
      if (mul_out_valid) begin
        lo_d    = mul_product[31:0];
        hi_d    = hi_corr;
        state_d = ST_IDLE;
      end
    end

    // MT* can only be accepted while idle, so it never collides with the result write.
    if (accept && (ex_op == OP_MTHI)) begin
      hi_d = rs_data;
    end
    if (accept && (ex_op == OP_MTLO)) begin
      lo_d = rs_data;
    end
  end

  // State registers; reset also discards any product still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      uns_q   <= uns_d;
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Randomized and directed bench for mult_hilo_ctrl with a two-cycle signed multiplier model.
// Latency: one DUT cycle per step; outputs sampled 1ns after the falling edge.
// Backpressure: stall is predicted from the reference model's outstanding-multiply window.
module tb_mult_hilo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hilo_rdata;
  logic        stall;
  logic        mul_in_valid;
  logic [31:0] mul_mcand;
  logic [31:0] mul_mplier;
  logic [63:0] mul_product;
  logic        mul_out_valid;

  mult_hilo_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_op         (ex_op),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .hilo_rdata    (hilo_rdata),
    .stall         (stall),
    .mul_in_valid  (mul_in_valid),
    .mul_mcand     (mul_mcand),
    .mul_mplier    (mul_mplier),
    .mul_product   (mul_product),
    .mul_out_valid (mul_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Downstream signed multiplier: one result slot, returned two cycles after launch.
  int          pend_cyc  = -1;
  logic [63:0] pend_prod = 64'd0;

  // Reference model: architectural HI/LO plus the window during which HI/LO is not yet final.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          m_busy = 1'b0;
  int          m_wr_cyc = -1;
  logic [31:0] r_hi, r_lo;

  logic [31:0] obs_rd;
  logic        obs_stall;
  logic        obs_miv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Full-precision product from the instruction's own signedness.
  task automatic ref_product(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    logic signed [63:0] sa, sb;
    if (op == 3'd2) begin
      p = {32'd0, a} * {32'd0, b};
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end
    hi = p[63:32];
    lo = p[31:0];
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rst);
    logic exp_stall, acc, exp_miv, hl, spur;
    logic [31:0] exp_rd;
    logic signed [63:0] sa, sb;
    @(negedge clk);
    rst_n    = ~rst;
    ex_valid = v;
    ex_op    = op;
    rs_data  = a;
    rt_data  = b;
    spur = !m_busy && ($urandom_range(0, 7) == 0);
    if (cyc == pend_cyc) begin
      mul_out_valid = 1'b1;
      mul_product   = pend_prod;
    end else begin
      mul_out_valid = spur;
      mul_product   = {$urandom, $urandom};
    end
    #1;
    hl        = v && (op >= 3'd1) && (op <= 3'd6);
    exp_stall = !rst && m_busy && hl;
    acc       = !rst && v && !exp_stall;
    exp_miv   = acc && ((op == 3'd1) || (op == 3'd2));
    exp_rd    = (acc && op == 3'd3) ? m_hi : (acc && op == 3'd4) ? m_lo : 32'd0;
    chk("stall", {63'd0, stall}, {63'd0, exp_stall});
    chk("mul_in_valid", {63'd0, mul_in_valid}, {63'd0, exp_miv});
    chk("hilo_rdata", {32'd0, hilo_rdata}, {32'd0, exp_rd});
    chk("mcand", {32'd0, mul_mcand}, {32'd0, a});
    chk("mplier", {32'd0, mul_mplier}, {32'd0, b});
    obs_rd    = hilo_rdata;
    obs_stall = stall;
    obs_miv   = mul_in_valid;
    if (mul_in_valid) begin
      sa        = {{32{mul_mcand[31]}}, mul_mcand};
      sb        = {{32{mul_mplier[31]}}, mul_mplier};
      pend_prod = sa * sb;
      pend_cyc  = cyc + 2;
    end
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_wr_cyc = -1;
    end else begin
      if (m_busy && cyc == m_wr_cyc) begin
        m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; m_wr_cyc = -1;
      end
      if (acc) begin
        case (op)
          3'd1, 3'd2: begin
            ref_product(op, a, b, r_hi, r_lo);
            m_busy   = 1'b1;
            m_wr_cyc = cyc + 2;
          end
          3'd5: m_hi = a;
          3'd6: m_lo = a;
          default: ;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic nop();
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    mul_product = 64'd0; mul_out_valid = 1'b0;

    // Outputs held quiet during reset even with a MULT/MFHI presented.
    step(1'b1, 3'd1, 32'h1234_5678, 32'h9, 1'b1);
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b1);
    chk("rst_rdata", {32'd0, obs_rd}, 64'd0);
    chk("rst_miv", {63'd0, obs_miv}, 64'd0);
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("reset_hi", {32'd0, obs_rd}, 64'd0);
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("reset_lo", {32'd0, obs_rd}, 64'd0);

    // Signed MULT of -1 by 2.
    step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    nop(); nop();
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("mult_hi", {32'd0, obs_rd}, {32'd0, 32'hFFFF_FFFF});
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("mult_lo", {32'd0, obs_rd}, {32'd0, 32'hFFFF_FFFE});

    // Same operands unsigned.
    step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
    nop(); nop();
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("multu_hi", {32'd0, obs_rd}, {32'd0, 32'h0000_0001});
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("multu_lo", {32'd0, obs_rd}, {32'd0, 32'hFFFF_FFFE});

    // Both sign bits set, unsigned.
    step(1'b1, 3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    nop(); nop();
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("multu_msb_hi", {32'd0, obs_rd}, {32'd0, 32'h4000_0000});
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("multu_msb_lo", {32'd0, obs_rd}, 64'd0);

    // MFLO right behind a MULT stalls two cycles.
    step(1'b1, 3'd1, 32'd3, 32'd5, 1'b0);
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("mflo_stall1", {63'd0, obs_stall}, 64'd1);
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("mflo_stall2", {63'd0, obs_stall}, 64'd1);
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("mflo_go", {63'd0, obs_stall}, 64'd0);
    chk("mflo_val", {32'd0, obs_rd}, 64'd15);

    // MTHI then MFHI, LO untouched.
    step(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("mthi_stall", {63'd0, obs_stall}, 64'd0);
    chk("mthi_val", {32'd0, obs_rd}, {32'd0, 32'h1234_5678});
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("mthi_lo_kept", {32'd0, obs_rd}, 64'd15);

    // Back-to-back MULT offered in the write cycle.
    step(1'b1, 3'd1, 32'd7, 32'd6, 1'b0);
    nop();
    step(1'b1, 3'd1, 32'd2, 32'd2, 1'b0);
    chk("b2b_stall", {63'd0, obs_stall}, 64'd1);
    step(1'b1, 3'd1, 32'd2, 32'd2, 1'b0);
    chk("b2b_accept", {63'd0, obs_miv}, 64'd1);
    nop(); nop();

    // Reset while a product is in flight; the late product must be dropped.
    step(1'b1, 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b1);
    chk("midrst_stall", {63'd0, obs_stall}, 64'd0);
    nop();
    step(1'b1, 3'd3, 32'd0, 32'd0, 1'b0);
    chk("midrst_hi", {32'd0, obs_rd}, 64'd0);
    chk("midrst_nostall", {63'd0, obs_stall}, 64'd0);
    step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
    chk("midrst_lo", {32'd0, obs_rd}, 64'd0);

    // Random instruction stream against the reference model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_word(), rand_word(),
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
